// File: rtl/wbu_pkg.sv
// Shared definitions for the write-back/commit stage: opcode constants, FSM
// states and the reference (RV32I-sized) commit-queue entry layout.
// No ports; imported by wbu_fifo's users and wbu_commit.
package wbu_pkg;

  // Major opcodes that steer next-PC and write-back selection.
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Reference entry widths (XLEN=32, RD_W=5, CSR_AW=12).
  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned RD_W_DEF   = 5;
  localparam int unsigned CSR_AW_DEF = 12;

  // Packages cannot take parameters, so this is the layout at the default
  // widths; wbu_commit declares the same field order at its own widths.
  typedef struct packed {
    logic                  gpr_wen;
    logic [RD_W_DEF-1:0]   rd;
    logic [XLEN_DEF-1:0]   gpr_wdata;
    logic                  csr_wen;
    logic [CSR_AW_DEF-1:0] csr_addr;
    logic [XLEN_DEF-1:0]   csr_wdata;
    logic [XLEN_DEF-1:0]   dnpc;
    logic                  is_ebreak;
  } wbu_entry_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } wbu_state_e;

endpackage

// File: rtl/wbu_commit_if.sv
// LSU->WBU enqueue handshake plus the retire-side GPR/CSR/IFU outputs.
// master: producer/consumer environment (LSU + register files + IFU).
// slave: the commit stage itself.
interface wbu_commit_if #(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter int CSR_AW = 12
);

  // Enqueue side
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_aluout;
  logic [XLEN-1:0]   in_csr_out;
  logic [XLEN-1:0]   in_rdata;
  logic              in_gpr_wen;
  logic [RD_W-1:0]   in_rd;
  logic              in_csr_wen;
  logic [CSR_AW-1:0] in_csr_waddr;
  logic [XLEN-1:0]   in_csr_wdata;
  logic              in_br_taken;
  logic              in_is_ecall;
  logic              in_is_mret;
  logic              in_is_ebreak;

  // Retire side
  logic              commit_valid;
  logic              commit_ready;
  logic              gpr_wen;
  logic [RD_W-1:0]   gpr_rd;
  logic [XLEN-1:0]   gpr_wdata;
  logic              csr_wen;
  logic [CSR_AW-1:0] csr_addr;
  logic [XLEN-1:0]   csr_wdata;
  logic              dnpc_valid;
  logic [XLEN-1:0]   dnpc;
  logic              halted;
  logic [63:0]       instret;

  modport master (
    output in_valid, in_opcode, in_pc, in_aluout, in_csr_out, in_rdata,
           in_gpr_wen, in_rd, in_csr_wen, in_csr_waddr, in_csr_wdata,
           in_br_taken, in_is_ecall, in_is_mret, in_is_ebreak, commit_ready,
    input  in_ready, commit_valid, gpr_wen, gpr_rd, gpr_wdata, csr_wen,
           csr_addr, csr_wdata, dnpc_valid, dnpc, halted, instret
  );

  modport slave (
    input  in_valid, in_opcode, in_pc, in_aluout, in_csr_out, in_rdata,
           in_gpr_wen, in_rd, in_csr_wen, in_csr_waddr, in_csr_wdata,
           in_br_taken, in_is_ecall, in_is_mret, in_is_ebreak, commit_ready,
    output in_ready, commit_valid, gpr_wen, gpr_rd, gpr_wdata, csr_wen,
           csr_addr, csr_wdata, dnpc_valid, dnpc, halted, instret
  );

endinterface

// File: rtl/wbu_fifo.sv
// Generic DEPTH x W synchronous circular FIFO with occupancy count.
// Latency: a write is visible on rd_dat_o the cycle after it is accepted.
// Backpressure: writes ignored when full, reads ignored when empty; no
// same-cycle bypass from write to read.
// Ports: clk/rst, wr_en_i/wr_dat_i, rd_en_i/rd_dat_o (head, show-ahead),
// count_o, full_o, empty_o.
module wbu_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [W-1:0]     wr_dat_i,
  input  logic             rd_en_i,
  output logic [W-1:0]     rd_dat_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_fire, rd_fire;

  // Explicit wrap so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign rd_dat_o = mem_q[rd_ptr_q];

  assign wr_fire = wr_en_i && !full_o;
  assign rd_fire = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_fire ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (wr_fire && !rd_fire) count_d = count_q + CNT_W'(1);
    if (rd_fire && !wr_fire) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: validity is tracked purely by count_q.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/wbu_commit.sv
// Write-back/commit stage: resolves write-back data and next PC at enqueue,
// buffers results and retires one instruction per cycle in order.
// Latency: accepted in cycle N, earliest commit_valid in cycle N+1.
// Backpressure: in_ready low when the queue is full or after ebreak retires.
// Ports: clk, rst (async, active-high), bus (wbu_commit_if.slave: LSU
// handshake in, GPR/CSR/dnpc/halted/instret out).
module wbu_commit
  import wbu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter int CSR_AW = 12,
  parameter int DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst,
  wbu_commit_if.slave   bus
);

  typedef struct packed {
    logic              gpr_wen;
    logic [RD_W-1:0]   rd;
    logic [XLEN-1:0]   gpr_wdata;
    logic              csr_wen;
    logic [CSR_AW-1:0] csr_addr;
    logic [XLEN-1:0]   csr_wdata;
    logic [XLEN-1:0]   dnpc;
    logic              is_ebreak;
  } entry_t;

  localparam int W     = $bits(entry_t);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           enq_entry, head, head_vis;
  logic [W-1:0]     head_raw;
  logic [CNT_W-1:0] q_count;
  logic             q_full, q_empty;
  logic             in_ready_w, enq_fire, commit_valid_w, ret_fire;
  logic [XLEN-1:0]  snpc;
  logic             is_jump;
  wbu_state_e       state_q, state_d;
  logic [63:0]      instret_q, instret_d;

  // Enqueue-side result resolution
  always_comb begin
    snpc      = bus.in_pc + XLEN'(4);
    is_jump   = (bus.in_opcode == OP_JAL) || (bus.in_opcode == OP_JALR);
    enq_entry = '0;

    enq_entry.gpr_wen   = bus.in_gpr_wen && (bus.in_rd != '0);
    enq_entry.rd        = bus.in_rd;
    enq_entry.csr_wen   = bus.in_csr_wen;
    enq_entry.csr_addr  = bus.in_csr_waddr;
    enq_entry.csr_wdata = bus.in_csr_wdata;
    enq_entry.is_ebreak = bus.in_is_ebreak;

    // Trap entry/return wins over branch/jump targets.
    if (bus.in_is_ecall || bus.in_is_mret) enq_entry.dnpc = bus.in_csr_out;
    else if (bus.in_br_taken || is_jump)   enq_entry.dnpc = bus.in_aluout;
    else                                   enq_entry.dnpc = snpc;

    if (is_jump)                           enq_entry.gpr_wdata = snpc;
    else if (bus.in_opcode == OP_LOAD)     enq_entry.gpr_wdata = bus.in_rdata;
    else if (bus.in_opcode == OP_SYSTEM)   enq_entry.gpr_wdata = bus.in_csr_out;
    else                                   enq_entry.gpr_wdata = bus.in_aluout;
  end

  // in_ready depends only on registered state, so a retire in this cycle
  // never opens a slot for an enqueue in the same cycle.
  assign in_ready_w     = !q_full && (state_q == S_RUN);
  assign enq_fire       = bus.in_valid && in_ready_w;
  assign commit_valid_w = (q_count != '0);
  assign ret_fire       = commit_valid_w && bus.commit_ready;

  wbu_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (enq_fire),
    .wr_dat_i (enq_entry),
    .rd_en_i  (ret_fire),
    .rd_dat_o (head_raw),
    .count_o  (q_count),
    .full_o   (q_full),
    .empty_o  (q_empty)
  );

  assign head     = entry_t'(head_raw);
  // Stale storage is never exposed: data outputs read zero when empty.
  assign head_vis = q_empty ? entry_t'('0) : head;

  assign bus.in_ready     = in_ready_w;
  assign bus.commit_valid = commit_valid_w;
  assign bus.gpr_wen      = ret_fire && head_vis.gpr_wen;
  assign bus.gpr_rd       = head_vis.rd;
  assign bus.gpr_wdata    = head_vis.gpr_wdata;
  assign bus.csr_wen      = ret_fire && head_vis.csr_wen;
  assign bus.csr_addr     = head_vis.csr_addr;
  assign bus.csr_wdata    = head_vis.csr_wdata;
  assign bus.dnpc_valid   = ret_fire;
  assign bus.dnpc         = head_vis.dnpc;
  assign bus.halted       = (state_q == S_HALT);
  assign bus.instret      = instret_q;

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    if (ret_fire) instret_d = instret_q + 64'd1;
    case (state_q)
      S_RUN:   if (ret_fire && head_vis.is_ebreak) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;  // only reset leaves HALT
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

endmodule
